// File: rtl/dp_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : dp_bram_stream_reader
// Purpose  : Read-side engine for a simple dual-port BRAM with a 1-cycle
//            registered read. On a start command it reads a contiguous
//            address range and delivers the words on a valid/ready stream.
//            A 2-entry skid FIFO plus a read-credit rule absorbs the BRAM
//            latency and downstream backpressure, so no word is lost or
//            duplicated.
// Ports    : clk, rst_n           - clock (shared with BRAM), async active-low reset
//            start, start_addr,   - command strobe (sampled only while idle),
//            num_words            - first address and word count (0..2**ADDR_WIDTH)
//            dir                  - direction, only with DP_BRAM_READER_REVERSE_EN
//            busy, done           - command status / one-cycle completion pulse
//            raddr, rd_issue      - BRAM read address, real-read indicator
//            bram_data            - BRAM read data (valid cycle after raddr)
//            out_valid/ready/data/last - output stream
// Config   : `define DP_BRAM_READER_REVERSE_EN adds the dir input; dir=1
//            walks addresses downward (wrapping 0 -> 2**ADDR_WIDTH-1).
// Revision : 1.0 - initial release
// ============================================================================
module dp_bram_stream_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
`ifdef DP_BRAM_READER_REVERSE_EN
    input  logic                  dir,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rd_issue,
    input  logic [DATA_WIDTH-1:0] bram_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_rem_one  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     remaining_q;
    logic                    dir_q;
    logic                    inflight_q;
    logic                    inflight_last_q;

    // 2-entry FIFO, one slot per possible outstanding read
    logic [DATA_WIDTH-1:0]   data0_q, data1_q;
    logic                    last0_q, last1_q;
    logic                    wr_ptr_q, rd_ptr_q;
    logic [1:0]              count_q, count_d;

    logic                    push_w, pop_w;
    logic [2:0]              credit_w;

    assign push_w    = inflight_q;
    assign out_valid = (count_q != 2'd0);
    assign pop_w     = out_valid & out_ready;
    assign out_data  = rd_ptr_q ? data1_q : data0_q;
    assign out_last  = out_valid & (rd_ptr_q ? last1_q : last0_q);

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign raddr = addr_q;

    // Words that will occupy the FIFO after this edge, excluding a new issue.
    // Keeping it below 2 before issuing means a returning read always has a slot.
    assign credit_w = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_w};
    assign rd_issue = (state_q == ST_BUSY) && (remaining_q != '0) && (credit_w < 3'd2);

    assign count_d = count_q + {1'b0, push_w} - {1'b0, pop_w};

`ifdef DP_BRAM_READER_REVERSE_EN
    assign addr_d = dir_q ? (addr_q - c_addr_one) : (addr_q + c_addr_one);
`else
    assign addr_d = addr_q + c_addr_one;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            dir_q           <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            data0_q         <= '0;
            data1_q         <= '0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            state_q     <= ST_BUSY;
                            addr_q      <= start_addr;
                            remaining_q <= num_words;
`ifdef DP_BRAM_READER_REVERSE_EN
                            dir_q       <= dir;
`else
                            dir_q       <= 1'b0;
`endif
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (pop_w && out_last)
                        state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase

            // rd_issue is only ever high in BUSY, so it never collides with the load above
            if (rd_issue) begin
                addr_q      <= addr_d;
                remaining_q <= remaining_q - c_rem_one;
            end

            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && (remaining_q == c_rem_one);

            if (push_w) begin
                if (wr_ptr_q) begin
                    data1_q <= bram_data;
                    last1_q <= inflight_last_q;
                end else begin
                    data0_q <= bram_data;
                    last0_q <= inflight_last_q;
                end
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_w)
                rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dp_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_bram_stream_reader
// Purpose  : Self-checking bench for dp_bram_stream_reader. A behavioural
//            BRAM feeds the DUT; each command's expected word sequence is
//            computed from address arithmetic and compared at every handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_bram_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] num_words;
    logic       dir;
    logic       busy, done, rd_issue, out_valid, out_last;
    logic [3:0] raddr;
    logic [7:0] bram_data;
    logic       out_ready;
    logic [7:0] out_data;

    logic [7:0] mem [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // 1-cycle registered-read BRAM
    always @(posedge clk) bram_data <= mem[raddr];

    dp_bram_stream_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_addr(start_addr),
        .num_words (num_words),
`ifdef DP_BRAM_READER_REVERSE_EN
        .dir       (dir),
`endif
        .busy      (busy),
        .done      (done),
        .raddr     (raddr),
        .rd_issue  (rd_issue),
        .bram_data (bram_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"},      {31'd0, busy},      32'd0);
        check_val({tag, "_done"},      {31'd0, done},      32'd0);
        check_val({tag, "_valid"},     {31'd0, out_valid}, 32'd0);
        check_val({tag, "_last"},      {31'd0, out_last},  32'd0);
        check_val({tag, "_rd_issue"},  {31'd0, rd_issue},  32'd0);
        check_val({tag, "_raddr"},     {28'd0, raddr},     32'd0);
        check_val({tag, "_data"},      {24'd0, out_data},  32'd0);
    endtask

    task automatic init_mem_default();
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16'h10);
    endtask

    // mode: 0 = ready always high, 1 = ready pattern 1,0,0,1,..., 2 = random ready
    // inject: pulse a different start command while busy (must be ignored)
    task automatic run_cmd(input logic [3:0] sa, input int n, input bit rev,
                           input int mode, input bit inject);
        logic [7:0] exp_d[$];
        bit         exp_l[$];
        int         issued, popped, first_v, done_c, done_cnt;
        bit         stall_prev;
        logic [7:0] pd;
        logic       pl;
        logic [3:0] a;
        issued = 0; popped = 0; first_v = -1; done_c = -1; done_cnt = 0;
        stall_prev = 1'b0; pd = '0; pl = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = rev ? 4'(sa - 4'(i)) : 4'(sa + 4'(i));
            exp_d.push_back(mem[a]);
            exp_l.push_back(i == n - 1);
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start = (c == 0) || (inject && c == 2);
            if (c == 0) begin
                start_addr = sa; num_words = 5'(n); dir = rev;
            end else if (inject && c == 2) begin
                start_addr = sa + 4'd5; num_words = 5'd3; dir = ~rev;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (c == 1 && n > 0) begin
                check_val("raddr_first", {28'd0, raddr}, {28'd0, sa});
                check_val("issue_first", {31'd0, rd_issue}, 32'd1);
            end
            if (c >= 1 && done_c < 0 && !done)
                check_val("busy_high", {31'd0, busy}, 32'd1);
            if (rd_issue) issued++;
            if (out_valid) begin
                if (first_v < 0) first_v = c;
                if (stall_prev) begin
                    check_val("stall_data", {24'd0, out_data}, {24'd0, pd});
                    check_val("stall_last", {31'd0, out_last}, {31'd0, pl});
                end
            end
            if (out_valid && out_ready) begin
                popped++;
                if (exp_d.size() > 0) begin
                    check_val("word_data", {24'd0, out_data}, {24'd0, exp_d.pop_front()});
                    check_val("word_last", {31'd0, out_last}, {31'd0, exp_l.pop_front()});
                end else begin
                    check_val("extra_word", popped, n);
                end
            end
            check_val("credit_le2", {31'd0, (issued - popped) <= 2}, 32'd1);
            stall_prev = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            if (done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c == done_c + 1) begin
                check_val("busy_after_done", {31'd0, busy}, 32'd0);
                check_val("done_one_cycle",  {31'd0, done}, 32'd0);
                break;
            end
        end
        start = 1'b0;
        check_val("done_seen",    {31'd0, done_c >= 0}, 32'd1);
        check_val("done_count",   done_cnt, 32'd1);
        check_val("words_left",   exp_d.size(), 32'd0);
        check_val("words_issued", issued, n);
        if (n > 0) begin
            check_val("first_valid_cycle", first_v, 32'd3);
            if (mode == 0) check_val("done_cycle", done_c, n + 3);
        end else begin
            check_val("zero_done_cycle", done_c, 32'd1);
            check_val("zero_no_valid",   {31'd0, first_v < 0}, 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; num_words = '0;
        dir = 1'b0; out_ready = 1'b0;
        init_mem_default();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic command, full throughput: 0x12..0x15 in cycles 3..6, done cycle 7
        run_cmd(4'd2, 4, 1'b0, 0, 1'b0);
        // Same command with stalls
        run_cmd(4'd2, 4, 1'b0, 1, 1'b0);
        // Address wrap 14,15,0,1
        run_cmd(4'd14, 4, 1'b0, 0, 1'b0);
        // Zero-length command
        run_cmd(4'd5, 0, 1'b0, 0, 1'b0);
        // Full memory
        run_cmd(4'd0, 16, 1'b0, 0, 1'b0);
        run_cmd(4'd0, 16, 1'b0, 1, 1'b0);
        // Start while busy is ignored
        run_cmd(4'd2, 6, 1'b0, 1, 1'b1);
`ifdef DP_BRAM_READER_REVERSE_EN
        // Descending walk 1,0,15 -> 0x11,0x10,0x1F
        run_cmd(4'd1, 3, 1'b1, 0, 1'b0);
        run_cmd(4'd1, 3, 1'b1, 1, 1'b0);
`endif

        // Reset mid-stream
        @(negedge clk);
        start = 1'b1; start_addr = 4'd3; num_words = 5'd10; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(4'd7, 5, 1'b0, 2, 1'b0);

        // Randomized commands over random memory contents
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 30; t++) begin
            bit rv;
`ifdef DP_BRAM_READER_REVERSE_EN
            rv = 1'($urandom_range(0, 1));
`else
            rv = 1'b0;
`endif
            run_cmd(4'($urandom_range(0, 15)), $urandom_range(0, 16), rv,
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
